// File: rtl/tt_harness_pkg.sv
// Shared types and sizing helpers for the tt_io_harness sequencing front end.
// The stimulus entry width depends on whether TT_HARNESS_CHECK_EN is compiled in.
package tt_harness_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PUSH = 2'd2
    } hs_state_e;

    localparam int ERR_CNT_W = 8;

    // Stimulus entry is {ui, uio} or, with checking, {ui, uio, exp, mask}.
    function automatic int stim_entry_w(input int data_w, input bit check_en);
        return check_en ? 4 * data_w : 2 * data_w;
    endfunction

endpackage

// File: rtl/tt_harness_fifo.sv
// Synchronous FIFO used for both the stimulus and response queues of tt_io_harness.
// No fall-through; one extra pointer bit separates full from empty.
module tt_harness_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // The storage array is not reset, so an empty FIFO presents zero rather than stale data.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tt_io_harness.sv
// I/O sequencing harness: queued stimulus, programmable apply-to-sample latency, uio merge,
// response FIFO. Optional expected-value checking is compiled in with TT_HARNESS_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for a stimulus entry; pops it and applies it to dut_* on leaving
// WAIT    | counting down lat cycles; samples the DUT into the hold register at zero
// PUSH    | writing the hold register into the response FIFO once it has space
module tt_io_harness
    import tt_harness_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int LAT_W  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [LAT_W-1:0]     lat,
    input  logic                 stim_valid,
    output logic                 stim_ready,
    input  logic [DATA_W-1:0]    stim_ui,
    input  logic [DATA_W-1:0]    stim_uio,
    input  logic [DATA_W-1:0]    stim_exp,
    input  logic [DATA_W-1:0]    stim_mask,
    output logic [DATA_W-1:0]    dut_ui_in,
    output logic [DATA_W-1:0]    dut_uio_in,
    input  logic [DATA_W-1:0]    dut_uo_out,
    input  logic [DATA_W-1:0]    dut_uio_out,
    input  logic [DATA_W-1:0]    dut_uio_oe,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [2*DATA_W-1:0]  resp_data,
    output logic                 resp_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 busy,
    output logic                 overflow
);

`ifdef TT_HARNESS_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif
    localparam int STIM_W = stim_entry_w(DATA_W, CHECK_EN);
    localparam int RESP_W = 2 * DATA_W + 1;

    hs_state_e          state_q;
    hs_state_e          state_d;
    logic [LAT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  ui_q;
    logic [DATA_W-1:0]  uio_q;
    logic [DATA_W-1:0]  hold_uo;
    logic [DATA_W-1:0]  hold_uio;
    logic               hold_err;

    logic [STIM_W-1:0]  stim_wdata;
    logic [STIM_W-1:0]  stim_rdata;
    logic               stim_full;
    logic               stim_empty;
    logic               stim_pop;

    logic [RESP_W-1:0]  resp_wdata;
    logic [RESP_W-1:0]  resp_rdata;
    logic               resp_full;
    logic               resp_empty;
    logic               resp_push;

    logic               sample;
    logic               mismatch;
    logic [DATA_W-1:0]  head_ui;
    logic [DATA_W-1:0]  head_uio;
    logic [DATA_W-1:0]  uio_merged;

`ifdef TT_HARNESS_CHECK_EN
    logic [DATA_W-1:0]  exp_q;
    logic [DATA_W-1:0]  mask_q;
    logic [DATA_W-1:0]  head_exp;
    logic [DATA_W-1:0]  head_mask;

    assign stim_wdata = {stim_ui, stim_uio, stim_exp, stim_mask};
    assign head_exp   = stim_rdata[2*DATA_W-1 -: DATA_W];
    assign head_mask  = stim_rdata[DATA_W-1:0];
    assign mismatch   = |((dut_uo_out ^ exp_q) & mask_q);
    assign resp_err   = resp_rdata[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q   <= '0;
            mask_q  <= '0;
            err_cnt <= '0;
        end else begin
            if (stim_pop) begin
                exp_q  <= head_exp;
                mask_q <= head_mask;
            end
            if (sample && mismatch && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    logic unused_ok;

    assign stim_wdata = {stim_ui, stim_uio};
    assign mismatch   = 1'b0;
    assign resp_err   = 1'b0;
    assign err_cnt    = '0;
    assign unused_ok  = ^{stim_exp, stim_mask, resp_rdata[0]};
`endif

    assign head_ui    = stim_rdata[STIM_W-1 -: DATA_W];
    assign head_uio   = stim_rdata[STIM_W-DATA_W-1 -: DATA_W];
    assign uio_merged = (dut_uio_out & dut_uio_oe) | (uio_q & ~dut_uio_oe);

    tt_harness_fifo #(.WIDTH(STIM_W), .DEPTH(DEPTH)) u_stim_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stim_valid),
        .wdata (stim_wdata),
        .pop   (stim_pop),
        .rdata (stim_rdata),
        .full  (stim_full),
        .empty (stim_empty)
    );

    assign resp_wdata = {hold_uo, hold_uio, hold_err};

    tt_harness_fifo #(.WIDTH(RESP_W), .DEPTH(DEPTH)) u_resp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (resp_push),
        .wdata (resp_wdata),
        .pop   (resp_ready),
        .rdata (resp_rdata),
        .full  (resp_full),
        .empty (resp_empty)
    );

    always_comb begin
        state_d   = state_q;
        stim_pop  = 1'b0;
        resp_push = 1'b0;
        sample    = 1'b0;
        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (!stim_empty) begin
                        stim_pop = 1'b1;
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        sample  = 1'b1;
                        state_d = ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    if (!resp_full) begin
                        resp_push = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ui_q     <= '0;
            uio_q    <= '0;
            hold_uo  <= '0;
            hold_uio <= '0;
            hold_err <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (stim_pop) begin
                ui_q  <= head_ui;
                uio_q <= head_uio;
                cnt_q <= lat;
            end else if (ena && (state_q == ST_WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (sample) begin
                hold_uo  <= dut_uo_out;
                hold_uio <= uio_merged;
                hold_err <= mismatch;
            end
            if (stim_valid && stim_full) overflow <= 1'b1;
        end
    end

    assign dut_ui_in  = ui_q;
    assign dut_uio_in = uio_q;
    assign stim_ready = !stim_full;
    assign resp_valid = !resp_empty;
    assign resp_data  = resp_rdata[RESP_W-1:1];
    assign busy       = (state_q != ST_IDLE) || !stim_empty;

endmodule

// File: tb/tb_tt_io_harness.sv
// Scoreboard bench for tt_io_harness with a behavioural DUT (uo = ui + 1).
// Checking-feature scenarios run only when TT_HARNESS_CHECK_EN is defined.
module tb_tt_io_harness;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int LAT_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic [LAT_W-1:0]  lat;
    logic              stim_valid;
    logic              stim_ready;
    logic [7:0]        stim_ui, stim_uio, stim_exp, stim_mask;
    logic [7:0]        dut_ui_in, dut_uio_in, dut_uo_out, dut_uio_out, dut_uio_oe;
    logic              resp_valid;
    logic              resp_ready;
    logic [15:0]       resp_data;
    logic              resp_err;
    logic [7:0]        err_cnt;
    logic              busy;
    logic              overflow;

    int n_cmp = 0;
    int n_err = 0;
    logic [16:0] sb [$];

    always #5 clk = ~clk;

    assign dut_uo_out = dut_ui_in + 8'd1;

    tt_io_harness #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .lat         (lat),
        .stim_valid  (stim_valid),
        .stim_ready  (stim_ready),
        .stim_ui     (stim_ui),
        .stim_uio    (stim_uio),
        .stim_exp    (stim_exp),
        .stim_mask   (stim_mask),
        .dut_ui_in   (dut_ui_in),
        .dut_uio_in  (dut_uio_in),
        .dut_uo_out  (dut_uo_out),
        .dut_uio_out (dut_uio_out),
        .dut_uio_oe  (dut_uio_oe),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .err_cnt     (err_cnt),
        .busy        (busy),
        .overflow    (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one accepted push and records the expected response.
    task automatic push_vec(input logic [7:0] ui, input logic [7:0] uio,
                            input logic [7:0] ex, input logic [7:0] mk);
        logic [7:0] uo_e;
        logic [7:0] mg_e;
        logic       er_e;
        uo_e = ui + 8'd1;
        mg_e = (dut_uio_out & dut_uio_oe) | (uio & ~dut_uio_oe);
`ifdef TT_HARNESS_CHECK_EN
        er_e = |((uo_e ^ ex) & mk);
`else
        er_e = 1'b0;
`endif
        stim_valid = 1'b1;
        stim_ui    = ui;
        stim_uio   = uio;
        stim_exp   = ex;
        stim_mask  = mk;
        sb.push_back({uo_e, mg_e, er_e});
        tick();
        stim_valid = 1'b0;
    endtask

    task automatic test_reset();
        int stale;
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++; if (dut_ui_in !== 8'h00) begin n_err++; $display("FAIL rst_ui: got %h want 00", dut_ui_in); end
        n_cmp++; if (dut_uio_in !== 8'h00) begin n_err++; $display("FAIL rst_uio: got %h want 00", dut_uio_in); end
        n_cmp++; if (stim_ready !== 1'b1) begin n_err++; $display("FAIL rst_stim_ready: got %b want 1", stim_ready); end
        n_cmp++; if ({resp_valid, busy, overflow, resp_err} !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {resp_valid, busy, overflow, resp_err}); end
        n_cmp++; if ({resp_data, err_cnt} !== 24'h0) begin n_err++; $display("FAIL rst_data: got %h want 000000", {resp_data, err_cnt}); end
        rst_n = 1'b1;
        tick();
        lat = 3'd7;
        push_vec(8'h77, 8'h22, 8'h00, 8'h00);
        tick();
        n_cmp++; if (dut_ui_in !== 8'h77) begin n_err++; $display("FAIL rst_pre_apply: got %h want 77", dut_ui_in); end
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({dut_ui_in, dut_uio_in} !== 16'h0) begin n_err++; $display("FAIL rst_mid_dut: got %h want 0000", {dut_ui_in, dut_uio_in}); end
        n_cmp++; if ({resp_valid, busy, overflow, stim_ready} !== 4'b0001) begin n_err++; $display("FAIL rst_mid_flags: got %b want 0001", {resp_valid, busy, overflow, stim_ready}); end
        tick();
        rst_n = 1'b1;
        sb.delete();
        stale = 0;
        for (int c = 0; c < 15; c++) begin
            if (resp_valid || busy) stale++;
            tick();
        end
        n_cmp++; if (stale !== 0) begin n_err++; $display("FAIL rst_stale: got %0d active cycles want 0", stale); end
    endtask

    task automatic test_basic();
        logic [16:0] e;
        lat = 3'd0;
        push_vec(8'h5A, 8'h11, 8'h5B, 8'hFF);
        n_cmp++; if (dut_ui_in !== 8'h00) begin n_err++; $display("FAIL basic_pre: got %h want 00", dut_ui_in); end
        tick();
        n_cmp++; if (dut_ui_in !== 8'h5A) begin n_err++; $display("FAIL basic_apply: got %h want 5A", dut_ui_in); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_p1: got %b want 0", resp_valid); end
        tick();
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_p2: got %b want 0", resp_valid); end
        tick();
        n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid_p3: got %b want 1", resp_valid); end
        e = sb.pop_front();
        n_cmp++; if ({resp_data, resp_err} !== e) begin n_err++; $display("FAIL basic_resp: got %h want %h", {resp_data, resp_err}, e); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL basic_popped: got %b want 0", resp_valid); end
    endtask

    task automatic test_uio_merge();
        logic [16:0] e;
        dut_uio_oe  = 8'hF0;
        dut_uio_out = 8'hAB;
        push_vec(8'h10, 8'h34, 8'h00, 8'h00);
        tick();
        n_cmp++; if (dut_uio_in !== 8'h34) begin n_err++; $display("FAIL merge_apply: got %h want 34", dut_uio_in); end
        resp_ready = 1'b1;
        for (int c = 0; c < 50 && sb.size() > 0; c++) begin
            if (resp_valid) begin
                e = sb.pop_front();
                n_cmp++; if ({resp_data, resp_err} !== e) begin n_err++; $display("FAIL merge_resp: got %h want %h", {resp_data, resp_err}, e); end
                n_cmp++; if (resp_data[7:0] !== 8'hA4) begin n_err++; $display("FAIL merge_low: got %h want A4", resp_data[7:0]); end
            end
            tick();
        end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL merge_timeout: got %0d left want 0", sb.size()); sb.delete(); end
        resp_ready  = 1'b0;
        dut_uio_oe  = 8'h00;
        dut_uio_out = 8'h00;
    endtask

    task automatic test_latency();
        logic [16:0] e;
        int cyc;
        logic [2:0] lats [3];
        lats = '{3'd0, 3'd3, 3'd7};
        for (int k = 0; k < 3; k++) begin
            lat = lats[k];
            push_vec(8'h20 + 8'(k), 8'h05, 8'h00, 8'h00);
            cyc = 0;
            while (!resp_valid && cyc < 40) begin tick(); cyc++; end
            n_cmp++; if (cyc != int'(lats[k]) + 3) begin n_err++; $display("FAIL lat_%0d: got %0d cycles want %0d", lats[k], cyc, int'(lats[k]) + 3); end
            e = sb.pop_front();
            n_cmp++; if ({resp_data, resp_err} !== e) begin n_err++; $display("FAIL lat_resp: got %h want %h", {resp_data, resp_err}, e); end
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
        end
    endtask

    task automatic test_ena_freeze();
        logic [16:0] e;
        int cyc;
        lat = 3'd5;
        push_vec(8'h3C, 8'h00, 8'h00, 8'h00);
        cyc = 0;
        tick(); cyc++;
        tick(); cyc++;
        ena = 1'b0;
        for (int c = 0; c < 10; c++) begin tick(); cyc++; end
        n_cmp++; if (dut_ui_in !== 8'h3C) begin n_err++; $display("FAIL freeze_ui: got %h want 3C", dut_ui_in); end
        n_cmp++; if ({busy, resp_valid} !== 2'b10) begin n_err++; $display("FAIL freeze_state: got %b want 10", {busy, resp_valid}); end
        ena = 1'b1;
        while (!resp_valid && cyc < 60) begin tick(); cyc++; end
        n_cmp++; if (cyc != 18) begin n_err++; $display("FAIL freeze_delay: got %0d cycles want 18", cyc); end
        e = sb.pop_front();
        n_cmp++; if ({resp_data, resp_err} !== e) begin n_err++; $display("FAIL freeze_resp: got %h want %h", {resp_data, resp_err}, e); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [16:0] e;
        int w;
        lat = 3'd0;
        resp_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            w = 0;
            while (!stim_ready && w < 100) begin tick(); w++; end
            if (!stim_ready) begin
                n_cmp++; n_err++;
                $display("FAIL bp_push_wait: got stim_ready 0 for vector %0d want 1", i);
            end else begin
                push_vec(8'(i), 8'(i), 8'(i + 1), 8'hFF);
            end
        end
        repeat (10) tick();
        n_cmp++; if ({stim_ready, resp_valid, busy} !== 3'b011) begin n_err++; $display("FAIL bp_stalled: got %b want 011", {stim_ready, resp_valid, busy}); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL bp_no_ovf: got %b want 0", overflow); end
        stim_valid = 1'b1;
        stim_ui    = 8'hEE;
        tick();
        stim_valid = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_ovf: got %b want 1", overflow); end
        resp_ready = 1'b1;
        for (int c = 0; c < 300 && sb.size() > 0; c++) begin
            if (resp_valid) begin
                e = sb.pop_front();
                n_cmp++; if ({resp_data, resp_err} !== e) begin n_err++; $display("FAIL bp_resp: got %h want %h", {resp_data, resp_err}, e); end
            end
            tick();
        end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL bp_lost: got %0d left want 0", sb.size()); sb.delete(); end
        resp_ready = 1'b0;
        repeat (3) tick();
        n_cmp++; if ({busy, resp_valid, overflow} !== 3'b001) begin n_err++; $display("FAIL bp_after: got %b want 001", {busy, resp_valid, overflow}); end
    endtask

`ifdef TT_HARNESS_CHECK_EN
    task automatic test_check();
        logic [16:0] e;
        int c;
        int exp_cnt;
        lat = 3'd0;
        push_vec(8'h5A, 8'h00, 8'h5B, 8'hFF);
        c = 0;
        while (!resp_valid && c < 20) begin tick(); c++; end
        e = sb.pop_front();
        n_cmp++; if ({resp_data, resp_err} !== e) begin n_err++; $display("FAIL chk_match_resp: got %h want %h", {resp_data, resp_err}, e); end
        n_cmp++; if ({resp_err, err_cnt} !== 9'h000) begin n_err++; $display("FAIL chk_match: got %h want 000", {resp_err, err_cnt}); end
        resp_ready = 1'b1; tick(); resp_ready = 1'b0;
        push_vec(8'h5A, 8'h00, 8'h00, 8'h0F);
        c = 0;
        while (!resp_valid && c < 20) begin tick(); c++; end
        e = sb.pop_front();
        n_cmp++; if ({resp_data, resp_err} !== e) begin n_err++; $display("FAIL chk_miss_resp: got %h want %h", {resp_data, resp_err}, e); end
        n_cmp++; if ({resp_err, err_cnt} !== 9'h101) begin n_err++; $display("FAIL chk_miss: got %h want 101", {resp_err, err_cnt}); end
        resp_ready = 1'b1; tick(); resp_ready = 1'b0;
        exp_cnt = 1;
        for (int i = 0; i < 300; i++) begin
            push_vec(8'(i), 8'h00, 8'(i), 8'hFF);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            c = 0;
            while (!resp_valid && c < 20) begin tick(); c++; end
            e = sb.pop_front();
            n_cmp++; if ({resp_data, resp_err} !== e) begin n_err++; $display("FAIL chk_sat_resp: got %h want %h", {resp_data, resp_err}, e); end
            resp_ready = 1'b1; tick(); resp_ready = 1'b0;
        end
        n_cmp++; if (err_cnt !== 8'(exp_cnt)) begin n_err++; $display("FAIL chk_sat: got %0d want %0d", err_cnt, exp_cnt); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        ena         = 1'b1;
        lat         = '0;
        stim_valid  = 1'b0;
        stim_ui     = '0;
        stim_uio    = '0;
        stim_exp    = '0;
        stim_mask   = '0;
        dut_uio_out = '0;
        dut_uio_oe  = '0;
        resp_ready  = 1'b0;
        test_reset();
        test_basic();
        test_uio_merge();
        test_latency();
        test_ena_freeze();
        test_back_to_back();
`ifdef TT_HARNESS_CHECK_EN
        test_check();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
